// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave memory serving read/write bursts from a word-addressed register array
// Ports: aclk/areset (sync, active-high); AR/R read channels (araddr..arvalid/arready, rdata/rresp/rlast/rvalid/rready);
// AW/W/B write channels (awaddr..awvalid/awready, wdata/wstrb/wlast/wvalid/wready, bresp/bvalid/bready).
// Read and write FSMs are independent so both directions run concurrently.
package axi_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [DATA_WIDTH/8-1:0] strb_t;
  typedef logic [1:0] resp_t;
  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR = 2'b01;
  localparam burst_t BURST_WRAP = 2'b10;
  localparam resp_t RESP_OKAY = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;
endpackage

module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter addr_t BASE_ADDR = '0
) (
  input  logic   aclk,
  input  logic   areset,
  input  addr_t  araddr,
  input  len_t   arlen,
  input  size_t  arsize,
  input  burst_t arburst,
  input  logic   arvalid,
  output logic   arready,
  output data_t  rdata,
  output resp_t  rresp,
  output logic   rlast,
  output logic   rvalid,
  input  logic   rready,
  input  addr_t  awaddr,
  input  len_t   awlen,
  input  size_t  awsize,
  input  burst_t awburst,
  input  logic   awvalid,
  output logic   awready,
  input  data_t  wdata,
  input  strb_t  wstrb,
  input  logic   wlast,
  input  logic   wvalid,
  output logic   wready,
  output resp_t  bresp,
  output logic   bvalid,
  input  logic   bready
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // d carries a borrow bit on top so addresses below BASE_ADDR are caught without a signed compare
  function automatic resp_t beat_err(logic [ADDR_WIDTH:0] d, size_t s, burst_t b);
    return (d[ADDR_WIDTH] || (d[ADDR_WIDTH-1:0] >> OFF) >= addr_t'(MEM_DEPTH)) ? RESP_DECERR :
           (b[1] || s > size_t'(OFF)) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  function automatic resp_t rmax(resp_t x, resp_t y);
    return x > y ? x : y;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wstate_t r_wstate, w_wnext;
  addr_t r_waddr, w_wnext_addr;
  len_t r_wlen, r_wcnt;
  size_t r_wsize;
  burst_t r_wburst;
  resp_t r_berr, w_werr, w_lerr;
  logic [ADDR_WIDTH:0] w_wsub;
  logic w_awhs, w_wfire, w_wend;

  assign w_awhs = awvalid && !areset && r_wstate == W_IDLE;
  assign w_wfire = wvalid && r_wstate == W_DATA;
  assign w_wend = r_wcnt == r_wlen;
  assign w_wsub = {1'b0, r_waddr} - {1'b0, BASE_ADDR};
  assign w_werr = beat_err(w_wsub, r_wsize, r_wburst);
  assign w_lerr = (wlast != w_wend) ? RESP_SLVERR : RESP_OKAY;
  assign w_wnext_addr = (r_wburst == BURST_FIXED) ? r_waddr : r_waddr + (addr_t'(1) << r_wsize);

  always_comb begin
    awready = !areset && r_wstate == W_IDLE;
    wready = r_wstate == W_DATA;
    bvalid = r_wstate == W_RESP;
    bresp = r_berr;
    w_wnext = r_wstate;
    if (w_awhs) w_wnext = W_DATA;
    if (w_wfire && w_wend) w_wnext = W_RESP;
    if (r_wstate == W_RESP && bready) w_wnext = W_IDLE;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wstate <= W_IDLE;
      r_berr <= RESP_OKAY;
    end else begin
      r_wstate <= w_wnext;
      if (w_awhs) begin
        r_waddr <= awaddr;
        r_wlen <= awlen;
        r_wsize <= awsize;
        r_wburst <= awburst;
        r_wcnt <= '0;
        r_berr <= RESP_OKAY;
      end
      if (w_wfire) begin
        r_waddr <= w_wnext_addr;
        r_wcnt <= r_wcnt + len_t'(1);
        r_berr <= rmax(r_berr, rmax(w_werr, w_lerr));
      end
    end
  end

  // wlast mismatch flags the response but does not block an otherwise legal write
  always_ff @(posedge aclk) begin
    if (w_wfire && w_werr == RESP_OKAY)
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (wstrb[b]) r_mem[w_wsub[OFF+AW-1:OFF]][8*b +: 8] <= wdata[8*b +: 8];
  end

  rstate_t r_rstate, w_rnext;
  addr_t r_raddr, w_ra;
  len_t r_rlen, r_rcnt;
  size_t r_rsize, w_rsz;
  burst_t r_rburst, w_rb;
  data_t r_rdata;
  resp_t r_rresp, w_rerr;
  logic [ADDR_WIDTH:0] w_rsub;
  logic w_arhs, w_rhs, w_rend, w_rload;

  assign w_arhs = arvalid && !areset && r_rstate == R_IDLE;
  assign w_rhs = rready && r_rstate == R_DATA;
  assign w_rend = r_rcnt == r_rlen;
  assign w_rload = w_arhs || (w_rhs && !w_rend);
  // beat data is fetched into a register one beat ahead, keeping rdata stable while stalled
  assign w_ra = (r_rstate == R_IDLE) ? araddr :
                (r_rburst == BURST_FIXED) ? r_raddr : r_raddr + (addr_t'(1) << r_rsize);
  assign w_rsz = (r_rstate == R_IDLE) ? arsize : r_rsize;
  assign w_rb = (r_rstate == R_IDLE) ? arburst : r_rburst;
  assign w_rsub = {1'b0, w_ra} - {1'b0, BASE_ADDR};
  assign w_rerr = beat_err(w_rsub, w_rsz, w_rb);

  always_comb begin
    arready = !areset && r_rstate == R_IDLE;
    rvalid = r_rstate == R_DATA;
    rlast = r_rstate == R_DATA && w_rend;
    rdata = r_rdata;
    rresp = r_rresp;
    w_rnext = r_rstate;
    if (w_arhs) w_rnext = R_DATA;
    if (w_rhs && w_rend) w_rnext = R_IDLE;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rstate <= R_IDLE;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      r_rstate <= w_rnext;
      if (w_rload) begin
        r_raddr <= w_ra;
        r_rsize <= w_rsz;
        r_rburst <= w_rb;
        r_rdata <= (w_rerr == RESP_OKAY) ? r_mem[w_rsub[OFF+AW-1:OFF]] : '0;
        r_rresp <= w_rerr;
      end
      if (w_arhs) begin
        r_rlen <= arlen;
        r_rcnt <= '0;
      end else if (w_rhs) r_rcnt <= r_rcnt + len_t'(1);
    end
  end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: scoreboard bench for axi_slave_mem
module tb_axi_slave_mem;
  import axi_pkg::*;
  logic aclk = 0, areset = 1;
  addr_t araddr = '0, awaddr = '0;
  len_t arlen = '0, awlen = '0;
  size_t arsize = '0, awsize = '0;
  burst_t arburst = '0, awburst = '0;
  logic arvalid = 0, rready = 0, awvalid = 0, wlast = 0, wvalid = 0, bready = 0;
  logic arready, rlast, rvalid, awready, wready, bvalid;
  data_t rdata, wdata = '0;
  strb_t wstrb = '0;
  resp_t rresp, bresp;

  axi_slave_mem #(.MEM_DEPTH(1024), .BASE_ADDR('0)) dut (
    .aclk(aclk), .areset(areset),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {data_t d; resp_t r; logic l;} rb_t;
  rb_t exp_r[$], obs_r[$];
  resp_t exp_b[$], obs_b[$];
  data_t wd[16];
  strb_t ws[16];
  int checks = 0, errors = 0;

  always @(negedge aclk) begin
    if (rvalid && rready) obs_r.push_back(rb_t'({rdata, rresp, rlast}));
    if (bvalid && bready) obs_b.push_back(bresp);
  end

  task automatic wr(input addr_t a, input len_t l, input size_t s, input burst_t b, input int lb);
    int n;
    @(posedge aclk); #1 awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1;
    n = 0; @(negedge aclk);
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) begin checks++; errors++; $display("FAIL aw_timeout awready %b want 1", awready); end
    @(posedge aclk); #1 awvalid = 0;
    for (int i = 0; i <= int'(l); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == lb); wvalid = 1;
      n = 0; @(negedge aclk);
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) begin checks++; errors++; $display("FAIL w_timeout wready %b want 1", wready); end
      @(posedge aclk); #1;
    end
    wvalid = 0; wlast = 0; bready = 1;
    n = 0; @(negedge aclk);
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL b_timeout bvalid %b want 1", bvalid); end
    @(posedge aclk); #1 bready = 0;
  endtask

  task automatic rd(input addr_t a, input len_t l, input size_t s, input burst_t b);
    int n;
    @(posedge aclk); #1 araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1;
    n = 0; @(negedge aclk);
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) begin checks++; errors++; $display("FAIL ar_timeout arready %b want 1", arready); end
    @(posedge aclk); #1 arvalid = 0; rready = 1;
    n = 0; @(negedge aclk);
    while (!(rvalid && rlast) && n < 300) begin @(negedge aclk); n++; end
    if (!(rvalid && rlast)) begin checks++; errors++; $display("FAIL r_timeout rlast %b want 1", rlast); end
    @(posedge aclk); #1 rready = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge aclk);
    checks++;
    if ({awready, arready, wready, rvalid, rlast, bvalid} !== 6'b0 || rdata !== '0 || rresp !== '0 || bresp !== '0) begin
      errors++;
      $display("FAIL reset_outputs got aw%b ar%b w%b rv%b rl%b b%b rdata %h rresp %b bresp %b want all 0",
               awready, arready, wready, rvalid, rlast, bvalid, rdata, rresp, bresp);
    end
    @(posedge aclk); #1 areset = 0;
    @(negedge aclk);
    checks++;
    if ({awready, arready} !== 2'b11) begin errors++; $display("FAIL reset_release got aw%b ar%b want 11", awready, arready); end
  endtask

  task automatic test_single;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    exp_b.push_back(RESP_OKAY);
    wr(32'h10, 0, 2, BURST_INCR, 0);
    exp_r.push_back({32'hDEADBEEF, RESP_OKAY, 1'b1});
    rd(32'h10, 0, 2, BURST_INCR);
    checks++;
    if (obs_r.size() != exp_r.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL single_count got r%0d b%0d want r%0d b%0d", obs_r.size(), obs_b.size(), exp_r.size(), exp_b.size());
    end
    while (exp_r.size() && obs_r.size()) begin
      rb_t e = exp_r.pop_front(), o = obs_r.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_rbeat got %h want %h", o, e); end
    end
    while (exp_b.size() && obs_b.size()) begin
      resp_t e = exp_b.pop_front(), o = obs_b.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL single_bresp got %b want %b", o, e); end
    end
    exp_r.delete(); obs_r.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_incr_stall;
    logic hold = 0, done = 0;
    data_t hd = '0;
    logic hl = 0;
    for (int i = 0; i < 4; i++) begin wd[i] = data_t'(i + 1); ws[i] = 4'hF; end
    exp_b.push_back(RESP_OKAY);
    wr(32'h0, 3, 2, BURST_INCR, 3);
    for (int i = 0; i < 4; i++) exp_r.push_back({data_t'(i + 1), RESP_OKAY, i == 3});
    @(posedge aclk); #1 araddr = 32'h0; arlen = 3; arsize = 2; arburst = BURST_INCR; arvalid = 1;
    @(negedge aclk);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL stall_arready got %b want 1", arready); end
    @(posedge aclk); #1 arvalid = 0; rready = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      if (hold) begin
        checks++;
        if (rdata !== hd || rlast !== hl || rvalid !== 1'b1) begin
          errors++; $display("FAIL stall_stable got %h/%b/%b want %h/%b/1", rdata, rlast, rvalid, hd, hl);
        end
      end
      hold = rvalid && !rready; hd = rdata; hl = rlast;
      if (rvalid && rready && rlast) begin done = 1; break; end
      @(posedge aclk); #1 rready = !rready;
    end
    @(posedge aclk); #1 rready = 0;
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout done %b want 1", done); end
    checks++;
    if (obs_r.size() != exp_r.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL stall_count got r%0d b%0d want r%0d b%0d", obs_r.size(), obs_b.size(), exp_r.size(), exp_b.size());
    end
    while (exp_r.size() && obs_r.size()) begin
      rb_t e = exp_r.pop_front(), o = obs_r.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_rbeat got %h want %h", o, e); end
    end
    while (exp_b.size() && obs_b.size()) begin
      resp_t e = exp_b.pop_front(), o = obs_b.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_bresp got %b want %b", o, e); end
    end
    exp_r.delete(); obs_r.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_fixed_strobe;
    wd[0] = 32'hAAAAAAAA; ws[0] = 4'h1;
    wd[1] = 32'hBBBBBBBB; ws[1] = 4'h2;
    wd[2] = 32'hCCCCCCCC; ws[2] = 4'hF;
    exp_b.push_back(RESP_OKAY);
    wr(32'h20, 2, 2, BURST_FIXED, 2);
    exp_r.push_back({32'hCCCCCCCC, RESP_OKAY, 1'b0});
    exp_r.push_back({32'hCCCCCCCC, RESP_OKAY, 1'b1});
    rd(32'h20, 1, 2, BURST_FIXED);
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    exp_b.push_back(RESP_OKAY);
    wr(32'h24, 0, 2, BURST_INCR, 0);
    wd[0] = 32'h0000AB00; ws[0] = 4'h2;
    exp_b.push_back(RESP_OKAY);
    wr(32'h24, 0, 2, BURST_INCR, 0);
    exp_r.push_back({32'h1234AB78, RESP_OKAY, 1'b1});
    rd(32'h24, 0, 2, BURST_INCR);
    checks++;
    if (obs_r.size() != exp_r.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL fixed_count got r%0d b%0d want r%0d b%0d", obs_r.size(), obs_b.size(), exp_r.size(), exp_b.size());
    end
    while (exp_r.size() && obs_r.size()) begin
      rb_t e = exp_r.pop_front(), o = obs_r.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL fixed_rbeat got %h want %h", o, e); end
    end
    while (exp_b.size() && obs_b.size()) begin
      resp_t e = exp_b.pop_front(), o = obs_b.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL fixed_bresp got %b want %b", o, e); end
    end
    exp_r.delete(); obs_r.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_decerr;
    wd[0] = 32'hBAD00000; wd[1] = 32'hBAD00001; ws[0] = 4'hF; ws[1] = 4'hF;
    exp_b.push_back(RESP_DECERR);
    wr(32'h1000, 1, 2, BURST_INCR, 1);
    exp_r.push_back({32'h1, RESP_OKAY, 1'b0});
    exp_r.push_back({32'h2, RESP_OKAY, 1'b1});
    rd(32'h0, 1, 2, BURST_INCR);
    exp_r.push_back({32'h0, RESP_DECERR, 1'b0});
    exp_r.push_back({32'h0, RESP_DECERR, 1'b1});
    rd(32'h1000, 1, 2, BURST_INCR);
    checks++;
    if (obs_r.size() != exp_r.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL decerr_count got r%0d b%0d want r%0d b%0d", obs_r.size(), obs_b.size(), exp_r.size(), exp_b.size());
    end
    while (exp_r.size() && obs_r.size()) begin
      rb_t e = exp_r.pop_front(), o = obs_r.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL decerr_rbeat got %h want %h", o, e); end
    end
    while (exp_b.size() && obs_b.size()) begin
      resp_t e = exp_b.pop_front(), o = obs_b.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL decerr_bresp got %b want %b", o, e); end
    end
    exp_r.delete(); obs_r.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_slverr;
    exp_r.push_back({32'h0, RESP_SLVERR, 1'b0});
    exp_r.push_back({32'h0, RESP_SLVERR, 1'b1});
    rd(32'h0, 1, 2, BURST_WRAP);
    exp_r.push_back({32'h0, RESP_SLVERR, 1'b1});
    rd(32'h0, 0, 3, BURST_INCR);
    for (int i = 0; i < 4; i++) begin wd[i] = data_t'(32'h41 + i); ws[i] = 4'hF; end
    exp_b.push_back(RESP_SLVERR);
    wr(32'h40, 3, 2, BURST_INCR, 1);
    for (int i = 0; i < 4; i++) exp_r.push_back({data_t'(32'h41 + i), RESP_OKAY, i == 3});
    rd(32'h40, 3, 2, BURST_INCR);
    checks++;
    if (obs_r.size() != exp_r.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL slverr_count got r%0d b%0d want r%0d b%0d", obs_r.size(), obs_b.size(), exp_r.size(), exp_b.size());
    end
    while (exp_r.size() && obs_r.size()) begin
      rb_t e = exp_r.pop_front(), o = obs_r.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL slverr_rbeat got %h want %h", o, e); end
    end
    while (exp_b.size() && obs_b.size()) begin
      resp_t e = exp_b.pop_front(), o = obs_b.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL slverr_bresp got %b want %b", o, e); end
    end
    exp_r.delete(); obs_r.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_concurrent_reset;
    for (int i = 0; i < 4; i++) begin wd[i] = data_t'(32'h81 + i); ws[i] = 4'hF; end
    exp_b.push_back(RESP_OKAY);
    for (int i = 0; i < 4; i++) exp_r.push_back({data_t'(i + 1), RESP_OKAY, i == 3});
    fork
      wr(32'h80, 3, 2, BURST_INCR, 3);
      rd(32'h0, 3, 2, BURST_INCR);
    join
    for (int i = 0; i < 4; i++) exp_r.push_back({data_t'(32'h81 + i), RESP_OKAY, i == 3});
    rd(32'h80, 3, 2, BURST_INCR);
    @(posedge aclk); #1 awaddr = 32'h104; awlen = 3; awsize = 2; awburst = BURST_INCR; awvalid = 1;
    @(negedge aclk);
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL mid_awready got %b want 1", awready); end
    @(posedge aclk); #1 awvalid = 0; wdata = 32'hCAFE0001; wstrb = 4'hF; wlast = 0; wvalid = 1;
    @(negedge aclk);
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL mid_wready got %b want 1", wready); end
    @(posedge aclk); #1 wvalid = 0; areset = 1;
    @(posedge aclk); @(negedge aclk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL mid_reset got aw%b w%b b%b ar%b rv%b want 0", awready, wready, bvalid, arready, rvalid);
    end
    @(posedge aclk); #1 areset = 0;
    @(negedge aclk);
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL post_reset_awready got %b want 1", awready); end
    wd[0] = 32'h55; ws[0] = 4'hF;
    exp_b.push_back(RESP_OKAY);
    wr(32'h100, 0, 2, BURST_INCR, 0);
    exp_r.push_back({32'h55, RESP_OKAY, 1'b0});
    exp_r.push_back({32'hCAFE0001, RESP_OKAY, 1'b1});
    rd(32'h100, 1, 2, BURST_INCR);
    checks++;
    if (obs_r.size() != exp_r.size() || obs_b.size() != exp_b.size()) begin
      errors++; $display("FAIL conc_count got r%0d b%0d want r%0d b%0d", obs_r.size(), obs_b.size(), exp_r.size(), exp_b.size());
    end
    while (exp_r.size() && obs_r.size()) begin
      rb_t e = exp_r.pop_front(), o = obs_r.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL conc_rbeat got %h want %h", o, e); end
    end
    while (exp_b.size() && obs_b.size()) begin
      resp_t e = exp_b.pop_front(), o = obs_b.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL conc_bresp got %b want %b", o, e); end
    end
    exp_r.delete(); obs_r.delete(); exp_b.delete(); obs_b.delete();
  endtask

  initial begin
    test_reset;
    test_single;
    test_incr_stall;
    test_fixed_strobe;
    test_decerr;
    test_slverr;
    test_concurrent_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time %0t want finish earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
